// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned IMEM_ADDR_W = 12;
    localparam int unsigned INSTR_W     = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: issues synchronous imem reads for the current PC and hands
// each instruction with its PC to decode over valid/ready.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = fetch_pkg::IMEM_ADDR_W,
    parameter int unsigned INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_in,
    input  logic               pc_valid,
    input  logic               redirect,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               pc_advance,
    output logic               fetch_fault
);

    fetch_state_t state, state_next;
    logic [31:0]  req_pc;

    logic in_range;
    logic req_ok;
    logic take;
    logic issue;
    logic fault;

    // A new PC may be consumed from IDLE or on the HOLD hand-off cycle.
    assign in_range = (pc_in[31:ADDR_W] == '0);
    assign req_ok   = pc_valid & ~redirect;
    assign take     = (state == IDLE) | ((state == HOLD) & instr_ready & ~redirect);
    assign issue    = take & req_ok & in_range;
    assign fault    = take & req_ok & ~in_range;

    assign imem_rd_en  = issue;
    assign pc_advance  = issue;
    assign imem_addr   = pc_in[ADDR_W-1:0];
    assign instr_valid = (state == HOLD) & ~redirect;
    assign fetch_fault = (state == FAULT);

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (issue)      state_next = WAIT;
                else if (fault) state_next = FAULT;
            end
            WAIT: begin
                if (redirect) state_next = IDLE;
                else          state_next = HOLD;
            end
            HOLD: begin
                if (redirect)         state_next = IDLE;
                else if (instr_ready) begin
                    if (issue)      state_next = WAIT;
                    else if (fault) state_next = FAULT;
                    else            state_next = IDLE;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request PC and output payload; data is captured only on a surviving WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc    <= '0;
            instr_out <= '0;
            instr_pc  <= '0;
        end else begin
            if (issue) begin
                req_pc <= pc_in;
            end
            if ((state == WAIT) && !redirect) begin
                instr_out <= imem_rdata;
                instr_pc  <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch with a transaction-level model.
module tb_instruction_fetch;

    localparam int unsigned AW    = 12;
    localparam int unsigned IW    = 9;
    localparam int unsigned DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc_in;
    logic          pc_valid;
    logic          redirect;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr_out;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          pc_advance;
    logic          fetch_fault;

    typedef struct packed {
        logic [31:0]   pc;
        logic [IW-1:0] ins;
    } exp_t;

    logic [IW-1:0] mem [DEPTH];
    exp_t          q[$];
    int            total = 0;
    int            bad   = 0;

    // Model: a read in flight, an instruction waiting for decode, or faulted.
    bit inflight = 0;
    bit holding  = 0;
    bit faulted  = 0;
    bit m_issue  = 0;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
        .redirect(redirect), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_advance(pc_advance), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        inflight = 0;
        holding  = 0;
        faulted  = 0;
        q.delete();
    endtask

    // One cycle: drive inputs after the falling edge, check against the model, advance model.
    task automatic step(input bit v, input logic [31:0] pc, input bit rd, input bit rdy);
        bit in_rng, tk, e_fault, e_valid;
        @(negedge clk);
        pc_valid = v; pc_in = pc; redirect = rd; instr_ready = rdy;
        #1;
        in_rng  = (pc < DEPTH);
        tk      = !faulted && !inflight && (!holding || (rdy && !rd));
        m_issue = tk && v && !rd && in_rng;
        e_fault = tk && v && !rd && !in_rng;
        e_valid = holding && !rd;
        chk("instr_valid", 32'(instr_valid), 32'(e_valid));
        chk("imem_rd_en", 32'(imem_rd_en), 32'(m_issue));
        chk("pc_advance", 32'(pc_advance), 32'(m_issue));
        chk("fetch_fault", 32'(fetch_fault), 32'(faulted));
        if (m_issue) chk("imem_addr", 32'(imem_addr), pc % DEPTH);
        if (rd) begin
            if (inflight || holding) void'(q.pop_back());
            inflight = 0;
            holding  = 0;
        end else begin
            if (holding && rdy) holding = 0;
            if (inflight) begin
                holding  = 1;
                inflight = 0;
            end
            if (m_issue) begin
                inflight = 1;
                q.push_back({pc, mem[pc % DEPTH]});
            end
            if (e_fault) faulted = 1;
        end
    endtask

    // Asserts reset in the middle of a cycle and checks outputs clear immediately.
    task automatic async_reset();
        @(negedge clk);
        pc_valid = 0; redirect = 0;
        #3;
        reset = 1;
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        chk("rst_pc_advance", 32'(pc_advance), 32'd0);
        chk("rst_imem_rd_en", 32'(imem_rd_en), 32'd0);
        model_clear();
        @(negedge clk);
        reset = 0;
    endtask

    // Monitor: pops the scoreboard on every transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && instr_valid && instr_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transfer actual pc=%0h required=none", instr_pc);
                end else begin
                    e = q.pop_front();
                    chk("xfer_instr", 32'(instr_out), 32'(e.ins));
                    chk("xfer_pc", instr_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_reg;
        bit v, rd, rdy;
        for (int i = 0; i < DEPTH; i++) mem[i] = IW'($urandom);
        mem[0] = 9'h0A5;
        reset = 1; pc_in = 0; pc_valid = 0; redirect = 0; instr_ready = 0;
        #1;
        chk("reset_instr_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr_out", 32'(instr_out), 32'd0);
        chk("reset_instr_pc", instr_pc, 32'd0);
        chk("reset_imem_rd_en", 32'(imem_rd_en), 32'd0);
        chk("reset_pc_advance", 32'(pc_advance), 32'd0);
        chk("reset_fetch_fault", 32'(fetch_fault), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 0;

        // Single fetch of word 0.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("single_instr_out", 32'(instr_out), 32'h0A5);
        chk("single_instr_pc", instr_pc, 32'd0);
        step(0, 0, 0, 1);

        // Stall in HOLD at PC 5, then hand-off with back-to-back issue of PC 6.
        step(1, 5, 0, 0);
        step(1, 6, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 6, 0, 0);
            chk("stall_instr_out", 32'(instr_out), 32'(mem[5]));
            chk("stall_instr_pc", instr_pc, 32'd5);
        end
        step(1, 6, 0, 1);
        chk("b2b_issue", 32'(imem_rd_en), 32'd1);
        step(0, 7, 0, 1);
        step(0, 7, 0, 1);
        step(0, 7, 0, 1);

        // Redirect while the read for PC 3 is in flight; next fetch is PC 20.
        step(1, 3, 0, 1);
        step(1, 3, 1, 1);
        step(1, 20, 0, 1);
        step(0, 21, 0, 1);
        step(0, 21, 0, 1);
        chk("redir_wait_pc", instr_pc, 32'd20);
        step(0, 21, 0, 1);

        // Redirect while holding with decode ready.
        step(1, 7, 0, 1);
        step(0, 8, 0, 1);
        step(1, 8, 1, 1);
        chk("redir_hold_valid", 32'(instr_valid), 32'd0);
        step(0, 8, 0, 1);

        // Randomized traffic; the bench plays the PC register.
        pc_reg = 32'($urandom_range(0, DEPTH - 1));
        for (int i = 0; i < 2000; i++) begin
            v   = ($urandom_range(0, 9) != 0);
            rd  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(v, pc_reg, rd, rdy);
            if (rd) pc_reg = ($urandom_range(0, 7) == 0) ? 32'(DEPTH - 1) : 32'($urandom_range(0, DEPTH - 1));
            else if (m_issue) pc_reg = (pc_reg == DEPTH - 1) ? 32'd0 : pc_reg + 32'd1;
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Range boundary: last word fetches, one past faults and sticks.
        step(1, 4095, 0, 1);
        step(0, 4095, 0, 1);
        step(0, 4095, 0, 1);
        chk("last_word_pc", instr_pc, 32'd4095);
        step(1, 4096, 0, 1);
        step(1, 10, 0, 1);
        chk("fault_set", 32'(fetch_fault), 32'd1);
        for (int i = 0; i < 4; i++) step(1, 32'(i), 0, 1);
        async_reset();
        step(0, 0, 0, 1);
        chk("fault_cleared", 32'(fetch_fault), 32'd0);

        // Reset while holding an instruction, then while a read is in flight.
        step(1, 9, 0, 0);
        step(0, 9, 0, 0);
        step(0, 9, 0, 0);
        async_reset();
        step(0, 0, 0, 1);
        step(1, 10, 0, 1);
        async_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(1, 11, 0, 1);
        step(0, 11, 0, 1);
        step(0, 11, 0, 1);
        step(0, 11, 0, 1);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
